// File: rtl/pwm_bus_arbiter.sv
// pwm_bus_arbiter: round-robin arbiter sharing one PWM register bus between two requesters
module pwm_bus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m0_we_i,
  input  logic       m1_we_i,
  input  logic [7:0] m0_addr_i,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m0_wdata_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m0_gnt_o,
  output logic       m1_gnt_o,
  output logic       m0_done_o,
  output logic       m1_done_o,
  output logic [7:0] m0_rdata_o,
  output logic [7:0] m1_rdata_o,
  output logic [7:0] b_addr_o,
  output logic [7:0] b_data_o,
  output logic [1:0] b_event_o,
  input  logic [7:0] b_data_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic last, win, win_nxt, we, any_req, last_wait;
  logic [2:0] cnt;
  assign any_req = m0_req_i | m1_req_i;
  // on a tie the requester that was not served last wins
  assign win_nxt = (m0_req_i & m1_req_i) ? ~last : m1_req_i;
  assign last_wait = cnt == 3'(RD_LATENCY - 1);
  always_comb begin
    state_nxt = state == IDLE  ? (any_req ? ISSUE : IDLE) :
                state == ISSUE ? (we ? DONE : WAIT) :
                state == WAIT  ? (last_wait ? DONE : WAIT) : IDLE;
    m0_gnt_o  = state == ISSUE && !win;
    m1_gnt_o  = state == ISSUE && win;
    m0_done_o = state == DONE && !win;
    m1_done_o = state == DONE && win;
    b_event_o = state == ISSUE ? (we ? 2'b01 : 2'b10) : 2'b00;
  end
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      state      <= IDLE;
      last       <= 1'b1;
      win        <= 1'b0;
      we         <= 1'b0;
      cnt        <= 3'd0;
      b_addr_o   <= 8'h00;
      b_data_o   <= 8'h00;
      m0_rdata_o <= 8'h00;
      m1_rdata_o <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= state == WAIT ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && any_req) begin
        win      <= win_nxt;
        last     <= win_nxt;
        we       <= win_nxt ? m1_we_i : m0_we_i;
        b_addr_o <= win_nxt ? m1_addr_i : m0_addr_i;
        b_data_o <= win_nxt ? m1_wdata_i : m0_wdata_i;
      end
      if (state == WAIT && last_wait && !win) m0_rdata_o <= b_data_i;
      if (state == WAIT && last_wait && win) m1_rdata_o <= b_data_i;
    end
endmodule

// File: doc/pwm_bus_arbiter.md
PWM_BUS_ARBITER -- requirements
Module: pwm_bus_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, is the number of clk_i cycles from a read strobe on b_event_o to valid b_data_i; the legal range is 1..7.
REQ-002 clk_i  input  1  single clock; all logic is rising-edge.
REQ-003 nrst_i  input  1  asynchronous, active-low reset.
REQ-004 m0_req_i / m1_req_i  input  1  transaction request level from requester 0 / 1.
REQ-005 m0_we_i / m1_we_i  input  1  1 = write, 0 = read; valid while req is high.
REQ-006 m0_addr_i / m1_addr_i  input  8  register address; valid while req is high.
REQ-007 m0_wdata_i / m1_wdata_i  input  8  write data; valid while req is high.
REQ-008 m0_gnt_o / m1_gnt_o  output  1  one-cycle pulse: request accepted, operands captured.
REQ-009 m0_done_o / m1_done_o  output  1  one-cycle pulse: transaction complete.
REQ-010 m0_rdata_o / m1_rdata_o  output  8  read result; valid from the done_o pulse of a read onward.
REQ-011 b_addr_o  output  8  shared PWM register-bus address.
REQ-012 b_data_o  output  8  shared register-bus write data.
REQ-013 b_event_o  output  2  bus strobe: 2'b01 = write, 2'b10 = read, 2'b00 = idle; 2'b11 is never driven.
REQ-014 b_data_i  input  8  register-bus read data from the PWM instances.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-016 IDLE: if any req is high at a clock edge, the block SHALL select a winner, capture its we/addr/wdata, and enter ISSUE; otherwise it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin over a last-served pointer.
- Single requester: that requester wins.
- Both requesting: the requester not last served wins.
- The pointer updates on grant only.
REQ-018 ISSUE, exactly one cycle:
- winner's gnt_o = 1;
- b_addr_o / b_data_o = captured values;
- b_event_o = 2'b01 for a write, 2'b10 for a read.
REQ-019 From ISSUE, a write SHALL go directly to DONE; a read SHALL go to WAIT.
REQ-020 WAIT SHALL last RD_LATENCY cycles, counted by a 3-bit counter; b_event_o = 2'b00 throughout.
REQ-021 On the last WAIT cycle, the block SHALL register b_data_i into the winner's rdata_o, then enter DONE.
REQ-022 DONE, exactly one cycle: winner's done_o = 1; the next state is IDLE.
REQ-023 Throughput: back-to-back writes take 3 cycles each (IDLE, ISSUE, DONE); back-to-back reads take 3+RD_LATENCY cycles each.
REQ-024 A requester SHALL deassert req in the cycle after it sees gnt_o.
- req is ignored outside IDLE.
- A req still high in IDLE starts a new transaction.
REQ-025 Once the block leaves IDLE, it SHALL ignore changes on the requester inputs (operands are already captured).
REQ-026 b_addr_o and b_data_o SHALL hold their last issued values between transactions.
REQ-027 Each rdata_o SHALL change only on a read completion belonging to that requester; writes never alter rdata_o.
REQ-028 Exactly one gnt_o and one done_o SHALL be asserted per transaction; gnt_o and done_o of different requesters SHALL never be asserted in the same cycle.
REQ-029 The losing requester's req SHALL remain pending with no loss; it SHALL be served in the immediately following IDLE.

Reset
REQ-030 While nrst_i is low, the following SHALL hold:
- state = IDLE;
- all gnt_o, done_o = 0;
- all rdata_o = 8'h00;
- b_addr_o, b_data_o = 8'h00;
- b_event_o = 2'b00;
- WAIT counter = 0;
- last-served pointer = requester 1, so requester 0 wins the first tie.
REQ-031 Reset asserted mid-transaction SHALL abort it with no done_o pulse.
REQ-032 After reset release, the first transaction SHALL start no earlier than the first rising edge with nrst_i high.

Verification
REQ-033 Single write: m0 writes addr 8'h03 data 8'hA5.
- Response: m0_gnt_o pulses and b_event_o = 2'b01 with b_addr_o = 8'h03, b_data_o = 8'hA5 in the same cycle; m0_done_o pulses one cycle later.
REQ-034 Read with RD_LATENCY = 3: m1 reads addr 8'h10 while b_data_i = 8'h5C.
- Response: b_event_o = 2'b10 for exactly one cycle; m1_done_o pulses 4 cycles after the strobe; m1_rdata_o = 8'h5C; m0_rdata_o unchanged.
REQ-035 Tie after reset: both requesters raise req in the same cycle, then keep re-requesting.
- Response: grant order is m0, m1, m0, m1; no gnt_o overlap.
REQ-036 Reset mid-read: nrst_i is pulled low during WAIT.
- Response: b_event_o = 2'b00; no done_o; rdata_o = 8'h00.
- After release, a new m0 write completes normally.
REQ-037 Streaming writes: m0 issues 4 back-to-back writes.
- Response: exactly 4 write strobes spaced 3 cycles apart; done_o count = 4; b_event_o never equals 2'b11.
